// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : definitions_pkg
//  Purpose  : Shared types for the convolution output path: memory address
//             and sequence number types, the output scheduler state encoding
//             and the queued output-pass descriptor.
//  Revision : 1.0  initial release
// ============================================================================
package definitions_pkg;

  typedef logic [15:0] mem_addr_t;
  typedef logic [7:0]  seq_t;

  // Output scheduler states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RUN  = 2'd3
  } out_sched_state_t;

  // One queued output pass
  typedef struct packed {
    mem_addr_t addr;
    mem_addr_t frame;
    seq_t      seq;
    logic      last;
    logic      newinst;
  } out_desc_t;

endpackage
`default_nettype wire

// File: rtl/out_desc_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : out_desc_fifo
//  Purpose  : Synchronous descriptor FIFO with occupancy count. Push at full
//             and pop at empty are ignored; clear empties it in one cycle.
//  Ports    : clock, resetN      - clock, asynchronous active-low reset
//             clear              - synchronous empty
//             push, pushData     - write strobe and descriptor
//             pop                - discard the head entry
//             headData           - current head entry (valid when !empty)
//             count, full, empty - occupancy status
//  Revision : 1.0  initial release
// ============================================================================
module out_desc_fifo
  import definitions_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     clear,
  input  logic                     push,
  input  out_desc_t                pushData,
  input  logic                     pop,
  output out_desc_t                headData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
  localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;

  out_desc_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign w_push   = push & ~full;
  assign w_pop    = pop & ~empty;
  assign count    = r_count;
  // DEPTH is a power of two and count never exceeds it, so the MSB alone marks full
  assign full     = r_count[c_PTR_W];
  assign empty    = (r_count == '0);
  assign headData = r_mem[r_rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + c_PTR_ONE;
      if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clock) begin
    if (w_push && !clear) r_mem[r_wrPtr] <= pushData;
  end

endmodule
`default_nettype wire

// File: rtl/conv_out_sched.sv
`default_nettype none
// ============================================================================
//  Module   : conv_out_sched
//  Purpose  : Queues output-pass descriptors and sequences them onto the
//             output path: load parameters, wait for the pre-output tile,
//             start the pass, and retire it on out_done.
//  Ports    : clock, resetN            - clock, asynchronous active-low reset
//             desc_*                   - descriptor push handshake and fields
//             compute_done, out_done   - tile-ready / pass-finished pulses
//             flush                    - synchronous abort
//             set_out_params, new_*    - parameter load strobe and values
//             set_LastOutput           - last-pass flag with the load strobe
//             newWriteInst_out         - next-instruction write request level
//             start_output             - start pulse for the output path
//             busy, count              - scheduler / queue status
//             finishedSeq, seq_done    - last completed instruction sequence
//             err_proto                - sticky out_done-outside-RUN error
//  Revision : 1.0  initial release
// ============================================================================
module conv_out_sched
  import definitions_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  mem_addr_t              desc_addr,
  input  mem_addr_t              desc_frame,
  input  seq_t                   desc_seq,
  input  logic                   desc_last,
  input  logic                   desc_newinst,
  input  logic                   compute_done,
  input  logic                   out_done,
  input  logic                   flush,
  output logic                   set_out_params,
  output mem_addr_t              new_outputAddr_out,
  output mem_addr_t              new_outputFrameStart_out,
  output logic                   set_LastOutput,
  output logic                   newWriteInst_out,
  output logic                   start_output,
  output logic                   busy,
  output seq_t                   finishedSeq,
  output logic                   seq_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_proto
);

  out_sched_state_t r_state;
  logic             r_pending;
  seq_t             r_actSeq;
  logic             r_actLast;

  out_desc_t        w_pushData;
  out_desc_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_loadNow;

  assign w_pushData = '{addr: desc_addr, frame: desc_frame, seq: desc_seq,
                        last: desc_last, newinst: desc_newinst};

  assign desc_ready = ~w_full;
  assign w_push     = desc_valid & desc_ready & ~flush;
  // The head stays in the queue during LOAD and is discarded at its end
  assign w_pop      = (r_state == ST_LOAD) & ~flush;
  assign busy       = (r_state != ST_IDLE);

  // A head descriptor is taken from IDLE, or straight out of a finished pass
  assign w_loadNow  = ~flush & ~w_empty &
                      ((r_state == ST_IDLE) | ((r_state == ST_RUN) & out_done));

  out_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .clear    (flush),
    .push     (w_push),
    .pushData (w_pushData),
    .pop      (w_pop),
    .headData (w_head),
    .count    (count),
    .full     (w_full),
    .empty    (w_empty)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state                  <= ST_IDLE;
      r_pending                <= 1'b0;
      r_actSeq                 <= '0;
      r_actLast                <= 1'b0;
      set_out_params           <= 1'b0;
      new_outputAddr_out       <= '0;
      new_outputFrameStart_out <= '0;
      set_LastOutput           <= 1'b0;
      newWriteInst_out         <= 1'b0;
      start_output             <= 1'b0;
      finishedSeq              <= '0;
      seq_done                 <= 1'b0;
      err_proto                <= 1'b0;
    end else begin
      set_out_params <= 1'b0;
      set_LastOutput <= 1'b0;
      start_output   <= 1'b0;
      seq_done       <= 1'b0;

      if (flush) begin
        // finishedSeq and err_proto deliberately survive a flush
        r_state          <= ST_IDLE;
        r_pending        <= 1'b0;
        newWriteInst_out <= 1'b0;
      end else begin
        if (out_done && (r_state != ST_RUN)) err_proto <= 1'b1;

        case (r_state)
          ST_IDLE: begin
            if (compute_done) r_pending <= 1'b1;
            if (!w_empty)     r_state   <= ST_LOAD;
          end
          ST_LOAD: begin
            if (compute_done) r_pending <= 1'b1;
            r_state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (compute_done || r_pending) begin
              start_output <= 1'b1;
              r_pending    <= 1'b0;
              r_state      <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (out_done) begin
              if (r_actLast) begin
                finishedSeq <= r_actSeq;
                seq_done    <= 1'b1;
              end
              r_state          <= w_empty ? ST_IDLE : ST_LOAD;
              newWriteInst_out <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase

        // Placed after the case so a back-to-back load overrides the clear above
        if (w_loadNow) begin
          set_out_params           <= 1'b1;
          set_LastOutput           <= w_head.last;
          new_outputAddr_out       <= w_head.addr;
          new_outputFrameStart_out <= w_head.frame;
          newWriteInst_out         <= w_head.newinst;
          r_actSeq                 <= w_head.seq;
          r_actLast                <= w_head.last;
        end
      end
    end
  end

endmodule
`default_nettype wire
